// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl: streams N samples into a parallel FFT, waits its latency, then streams N bins out.
module fft_frame_ctrl #(
    parameter int N            = 8,
    parameter int SAMPLE_WIDTH = 16,
    parameter int FFT_LATENCY  = 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                abort,
    input  logic                                s_valid,
    input  logic [SAMPLE_WIDTH-1:0]             s_data,
    output logic                                s_ready,
    output logic [N-1:0][SAMPLE_WIDTH-1:0]      fft_data_in,
    input  logic [N-1:0][SAMPLE_WIDTH-1:0]      fft_data_out,
    output logic                                m_valid,
    output logic [SAMPLE_WIDTH-1:0]             m_data,
    output logic                                m_last,
    input  logic                                m_ready,
    output logic                                busy,
    output logic                                frame_done
);
    localparam int CW = $clog2(N);
    localparam int LW = $clog2(FFT_LATENCY + 1);

    typedef enum logic [1:0] {COLLECT, WAIT, DRAIN} state_t;

    state_t                          state, state_nx;
    logic [CW-1:0]                   in_cnt, out_cnt;
    logic [LW-1:0]                   lat_cnt;
    logic [N-1:0][SAMPLE_WIDTH-1:0]  in_buf, out_buf;
    logic                            in_hs, out_hs, in_last, out_last, lat_hit;

    assign s_ready     = (state == COLLECT) && !rst;
    assign m_valid     = (state == DRAIN);
    assign m_data      = m_valid ? out_buf[out_cnt] : '0;
    assign m_last      = m_valid && out_last;
    assign busy        = (state != COLLECT);
    assign fft_data_in = in_buf;

    always_comb begin
        in_hs    = s_valid && s_ready;
        out_hs   = m_valid && m_ready;
        in_last  = (in_cnt == CW'(N - 1));
        out_last = (out_cnt == CW'(N - 1));
        lat_hit  = (lat_cnt == LW'(FFT_LATENCY));
        state_nx = abort                                  ? COLLECT :
                   (state == COLLECT && in_hs && in_last) ? WAIT    :
                   (state == WAIT && lat_hit)             ? DRAIN   :
                   (state == DRAIN && out_hs && out_last) ? COLLECT : state;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= COLLECT;
        else
            state <= state_nx;
    end

    // Abort clears the counters but deliberately keeps both buffers.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_cnt     <= '0;
            out_cnt    <= '0;
            lat_cnt    <= '0;
            in_buf     <= '0;
            out_buf    <= '0;
            frame_done <= 1'b0;
        end else if (abort) begin
            in_cnt     <= '0;
            out_cnt    <= '0;
            lat_cnt    <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= out_hs && out_last;
            lat_cnt    <= (state == WAIT && !lat_hit) ? lat_cnt + 1'b1 : '0;
            if (in_hs) begin
                in_buf[in_cnt] <= s_data;
                in_cnt         <= in_last ? '0 : in_cnt + 1'b1;
            end
            if (state == WAIT && lat_hit) begin
                out_buf <= fft_data_out;
                out_cnt <= '0;
            end
            if (out_hs)
                out_cnt <= out_last ? '0 : out_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_fft_frame_ctrl.sv
// tb_fft_frame_ctrl: directed and random traffic checked against a frame-level queue model.
module tb_fft_frame_ctrl;
    localparam int N  = 8;
    localparam int SW = 16;
    localparam int L  = 1;
    localparam int W  = N * SW;

    typedef logic [N-1:0][SW-1:0] frame_t;

    logic          clk = 1'b0;
    logic          rst, abort, s_valid, s_ready, m_valid, m_last, m_ready, busy, frame_done;
    logic [SW-1:0] s_data, m_data;
    frame_t        fft_data_in, fft_data_out;
    frame_t        pipe [L];

    fft_frame_ctrl #(.N(N), .SAMPLE_WIDTH(SW), .FFT_LATENCY(L)) dut (
        .clk(clk), .rst(rst), .abort(abort), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready), .fft_data_in(fft_data_in), .fft_data_out(fft_data_out),
        .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
        .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Stand-in for fft_np: reversed order, fixed xor, L register stages.
    function automatic frame_t fmodel(input frame_t x);
        frame_t r;
        for (int i = 0; i < N; i++) r[i] = x[N-1-i] ^ 16'h3C5A;
        return r;
    endfunction

    always @(posedge clk) begin
        pipe[0] <= fmodel(fft_data_in);
        for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
    end
    assign fft_data_out = pipe[L-1];

    logic [SW-1:0] mbuf [N];
    logic [SW-1:0] in_q [$];
    logic [SW-1:0] exp_q [$];
    bit            inflight, fd_exp;
    int            cyc, ready_cyc, acc_total, checks, failures;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic bit mr_of(input int mode, input int c);
        return (mode == 0) ? 1'b1 : (c % 4 == 0 || c % 4 == 3);
    endfunction

    task automatic tick(input logic v, input logic [SW-1:0] d, input logic mr, input logic ab, input logic r);
        bit     acc, ohs, mv_exp;
        frame_t pk, g;
        s_valid = v; s_data = d; m_ready = mr; abort = ab; rst = r;
        #1;
        mv_exp = inflight && cyc >= ready_cyc;
        for (int i = 0; i < N; i++) pk[i] = mbuf[i];
        chk("s_ready", s_ready, !inflight && !r);
        chk("busy", busy, inflight);
        chk("m_valid", m_valid, mv_exp);
        chk("m_last", m_last, mv_exp && exp_q.size() == 1);
        chk("frame_done", frame_done, fd_exp);
        chk("fft_data_in", fft_data_in, pk);
        if (mv_exp) chk("m_data", m_data, exp_q[0]);
        acc = v && !inflight && !r;
        ohs = mr && mv_exp;
        @(posedge clk);
        cyc++;
        if (r) begin
            in_q.delete(); exp_q.delete(); inflight = 0; fd_exp = 0;
            for (int i = 0; i < N; i++) mbuf[i] = '0;
        end else if (ab) begin
            in_q.delete(); exp_q.delete(); inflight = 0; fd_exp = 0;
        end else begin
            fd_exp = ohs && exp_q.size() == 1;
            if (ohs) begin
                void'(exp_q.pop_front());
                if (exp_q.size() == 0) inflight = 0;
            end
            if (acc) begin
                mbuf[in_q.size()] = d;
                in_q.push_back(d);
                acc_total++;
                if (in_q.size() == N) begin
                    inflight  = 1;
                    ready_cyc = cyc + L + 1;
                    for (int i = 0; i < N; i++) pk[i] = mbuf[i];
                    g = fmodel(pk);
                    for (int i = 0; i < N; i++) exp_q.push_back(g[i]);
                    in_q.delete();
                end
            end
        end
        #1;
    endtask

    task automatic send(input int n, input int gap, input int mode, input bit dir);
        int            start, c, k;
        logic [SW-1:0] d;
        start = acc_total; c = 0; k = 0;
        d = dir ? 16'h0101 : SW'($urandom);
        while (acc_total - start < n && c < 400) begin
            tick(c % gap == 0, d, mr_of(mode, c), 1'b0, 1'b0);
            if (acc_total - start > k) begin
                k++;
                d = dir ? {8'(k + 1), 8'(k + 1)} : SW'($urandom);
            end
            c++;
        end
        chk("send_timeout", acc_total - start, n);
    endtask

    task automatic drain(input int mode);
        int c;
        c = 0;
        while (inflight && c < 400) begin
            tick(1'b0, '0, mr_of(mode, c), 1'b0, 1'b0);
            c++;
        end
        chk("drain_timeout", inflight, 0);
    endtask

    initial begin
        frame_t ref_in;
        int     c;
        for (int i = 0; i < N; i++) mbuf[i] = '0;
        rst = 1; abort = 0; s_valid = 0; s_data = '0; m_ready = 0;
        @(posedge clk); #1;
        tick(1'b1, '0, 1'b0, 1'b0, 1'b1);
        tick(1'b0, '0, 1'b0, 1'b1, 1'b1);
        chk("reset_m_data", m_data, 0);
        chk("reset_fft_in", fft_data_in, 0);

        send(8, 1, 0, 1);
        for (int i = 0; i < N; i++) ref_in[i] = {8'(i + 1), 8'(i + 1)};
        chk("directed_fft_in", fft_data_in, ref_in);
        drain(0);

        send(8, 1, 1, 0);
        drain(1);

        send(8, 3, 0, 0);
        drain(0);

        send(5, 1, 0, 0);
        tick(1'b1, 16'hBEEF, 1'b1, 1'b1, 1'b0);
        send(8, 1, 0, 0);
        drain(0);

        send(8, 1, 0, 0);
        c = 0;
        while (exp_q.size() != N - 3 && c < 100) begin
            tick(1'b0, '0, 1'b1, 1'b0, 1'b0);
            c++;
        end
        chk("reach_bin3", exp_q.size(), N - 3);
        tick(1'b0, '0, 1'b1, 1'b0, 1'b1);
        chk("rst_drain_m_valid", m_valid, 0);
        chk("rst_drain_m_data", m_data, 0);
        for (int i = 0; i < 4; i++) tick(1'b0, '0, 1'b1, 1'b0, 1'b0);

        send(16, 1, 0, 0);
        drain(0);

        for (int i = 0; i < 300; i++)
            tick(1'($urandom_range(1)), SW'($urandom), 1'($urandom_range(1)),
                 $urandom_range(29) == 0, $urandom_range(99) == 0);
        drain(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
